// File: rtl/toggle_pkg.sv
// Shared encodings for the toggle arbiter: FSM states and shared-bit values.
package toggle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  typedef enum logic {
    ZERO = 1'b0,
    ONE  = 1'b1
  } res_e;

endpackage

// File: rtl/toggle_arbiter_rr_pick.sv
// Rotating first-one selector: first set req bit at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    idx
);

  logic [IW:0] sum;
  logic        found;

  always_comb begin
    pick  = '0;
    idx   = '0;
    sum   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        idx   = sum[IW-1:0];
        pick  = N_REQ'(1) << sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/toggle_arbiter.sv
// Round-robin arbiter granting ownership of a shared one-bit toggle state.
// state   | meaning
// IDLE    | no owner; arbitrate from ptr when any req is set
// GRANT   | owner drives res_state; tenure capped at MAX_HOLD cycles
// RELEASE | mandatory dead cycle; ptr advances past the previous owner
module toggle_arbiter
  import toggle_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] a,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             res_state,
  output logic             timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_REQ  = IW'(N_REQ - 1);

  state_e           state_q;
  res_e             res_q;
  logic [N_REQ-1:0] gnt_q;
  logic             busy_q;
  logic             timeout_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    owner_q;
  logic [HW-1:0]    hold_cnt_q;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick_oh),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      res_q      <= ZERO;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q    <= pick_idx;
            gnt_q      <= pick_oh;
            hold_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (res_q == ZERO && a[owner_q])       res_q <= ONE;
          else if (res_q == ONE && !a[owner_q])  res_q <= ZERO;
          // A voluntary release in the expiry cycle is not a timeout.
          if (!req[owner_q]) begin
            gnt_q   <= '0;
            state_q <= RELEASE;
          end else if (hold_cnt_q == HOLD_LAST) begin
            gnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= RELEASE;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        RELEASE: begin
          ptr_q   <= (owner_q == LAST_REQ) ? '0 : owner_q + IW'(1);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign res_state = res_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_toggle_arbiter.sv
// Directed scenarios plus randomized traffic against a tenure-level reference model.
module tb_toggle_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, a, gnt;
  logic         busy, res_state, timeout;

  always #5 clk = ~clk;

  toggle_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a         (a),
    .gnt       (gnt),
    .busy      (busy),
    .res_state (res_state),
    .timeout   (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current tenure owner (-1 none), cycles granted so far,
  // whether we sit in the dead cycle, next search start, shared bit, timeout.
  int m_owner = -1;
  int m_held  = 0;
  int m_next  = 0;
  bit m_dead  = 1'b0;
  bit m_res   = 1'b0;
  bit m_to    = 1'b0;

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] one;
    one = 1;
    if (m_owner < 0) return '0;
    return one << m_owner;
  endfunction

  function automatic bit exp_busy();
    return (m_owner >= 0) || m_dead;
  endfunction

  task automatic model_step(input bit r, input logic [N-1:0] rq, input logic [N-1:0] av);
    m_to = 1'b0;
    if (r) begin
      m_owner = -1; m_held = 0; m_next = 0; m_dead = 1'b0; m_res = 1'b0;
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else if (m_owner >= 0) begin
      m_res  = av[m_owner];
      m_held = m_held + 1;
      if (!rq[m_owner] || m_held == MH) begin
        m_to    = rq[m_owner];
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
        m_dead  = 1'b1;
      end
    end else if (rq != 0) begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && rq[(m_next + k) % N]) m_owner = (m_next + k) % N;
      m_held = 0;
    end
  endtask

  task automatic tick(input bit r, input logic [N-1:0] rq, input logic [N-1:0] av);
    @(negedge clk);
    rst = r; req = rq; a = av;
    @(posedge clk);
    model_step(r, rq, av);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 4'b1111, 4'b1111);
    tick(1'b1, 4'b0000, 4'b1111);
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_checks++;
    if (busy !== 1'b0 || timeout !== 1'b0 || res_state !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got busy=%b timeout=%b res=%b expected 0 0 0", busy, timeout, res_state);
    end
  endtask

  task automatic test_single();
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 4'b0001, 4'b0000);
      n_checks++;
      if (gnt !== 4'b0001 || busy !== 1'b1) begin
        n_fail++; $display("FAIL single_grant c%0d: got gnt=%b busy=%b expected 0001 1", c, gnt, busy);
      end
    end
    tick(1'b0, 4'b0000, 4'b0000);
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b1 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL single_release: got gnt=%b busy=%b to=%b expected 0000 1 0", gnt, busy, timeout);
    end
    tick(1'b0, 4'b0000, 4'b0000);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
    tick(1'b0, 4'b0011, 4'b0000);
    n_checks++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL single_ptr: got gnt=%b expected 0010", gnt); end
    tick(1'b0, 4'b0001, 4'b0000);
    tick(1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp;
    logic [N-1:0] one;
    one = 1;
    tick(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      exp = one << (i % N);
      tick(1'b0, 4'b1111, 4'b0000);
      n_checks++;
      if (gnt !== exp) begin n_fail++; $display("FAIL rot_grant%0d: got %b expected %b", i, gnt, exp); end
      tick(1'b0, 4'b1111, 4'b0000);
      n_checks++;
      if (gnt !== exp) begin n_fail++; $display("FAIL rot_hold%0d: got %b expected %b", i, gnt, exp); end
      tick(1'b0, 4'b1111 & ~exp, 4'b0000);
      n_checks++;
      if (gnt !== 4'b0000 || busy !== 1'b1) begin
        n_fail++; $display("FAIL rot_release%0d: got gnt=%b busy=%b expected 0000 1", i, gnt, busy);
      end
      tick(1'b0, 4'b1111, 4'b0000);
      n_checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rot_idle%0d: got gnt=%b busy=%b expected 0000 0", i, gnt, busy);
      end
    end
  endtask

  task automatic test_timeout();
    tick(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < MH; c++) begin
      tick(1'b0, 4'b0100, 4'b0000);
      n_checks++;
      if (gnt !== 4'b0100 || timeout !== 1'b0) begin
        n_fail++; $display("FAIL to_grant c%0d: got gnt=%b to=%b expected 0100 0", c, gnt, timeout);
      end
    end
    tick(1'b0, 4'b0100, 4'b0000);
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      n_fail++; $display("FAIL to_pulse: got gnt=%b to=%b expected 0000 1", gnt, timeout);
    end
    tick(1'b0, 4'b0100, 4'b0000);
    n_checks++;
    if (timeout !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL to_clear: got to=%b busy=%b expected 0 0", timeout, busy);
    end
    tick(1'b0, 4'b0100, 4'b0000);
    n_checks++;
    if (gnt !== 4'b0100) begin n_fail++; $display("FAIL to_regrant: got %b expected 0100", gnt); end
    tick(1'b0, 4'b0000, 4'b0000);
    tick(1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic test_res_state();
    logic [N-1:0] aseq [3];
    logic         rexp [3];
    aseq = '{4'b0101, 4'b0101, 4'b0001};
    rexp = '{1'b1, 1'b1, 1'b0};
    tick(1'b1, 4'b0000, 4'b0000);
    tick(1'b0, 4'b0100, 4'b0101);
    n_checks++;
    if (gnt !== 4'b0100 || res_state !== 1'b0) begin
      n_fail++; $display("FAIL res_arb: got gnt=%b res=%b expected 0100 0", gnt, res_state);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'b0100, aseq[i]);
      n_checks++;
      if (res_state !== rexp[i]) begin
        n_fail++; $display("FAIL res_seq%0d: got %b expected %b", i, res_state, rexp[i]);
      end
    end
    tick(1'b0, 4'b0000, 4'b0001);
    tick(1'b0, 4'b0000, 4'b1111);
    n_checks++;
    if (res_state !== 1'b0) begin n_fail++; $display("FAIL res_hold: got %b expected 0", res_state); end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 4'b0000, 4'b0000);
    tick(1'b0, 4'b0001, 4'b0000);
    tick(1'b0, 4'b0001, 4'b0001);
    n_checks++;
    if (gnt !== 4'b0001 || res_state !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: got gnt=%b res=%b expected 0001 1", gnt, res_state);
    end
    tick(1'b1, 4'b0001, 4'b0001);
    n_checks++;
    if (gnt !== 4'b0000 || res_state !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_rst: got gnt=%b res=%b to=%b busy=%b expected 0000 0 0 0",
                         gnt, res_state, timeout, busy);
    end
    tick(1'b0, 4'b1000, 4'b0000);
    n_checks++;
    if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rmid_regrant: got %b expected 1000", gnt); end
    tick(1'b0, 4'b0000, 4'b0000);
    tick(1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic test_release_at_expiry();
    tick(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < MH; c++) begin
      tick(1'b0, 4'b0001, 4'b0000);
      n_checks++;
      if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rexp_grant c%0d: got %b expected 0001", c, gnt); end
    end
    tick(1'b0, 4'b0000, 4'b0000);
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rexp_release: got gnt=%b to=%b busy=%b expected 0000 0 1", gnt, timeout, busy);
    end
    tick(1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic test_random();
    logic [N-1:0] rq;
    logic [N-1:0] ex;
    bit           r;
    rq = '0;
    tick(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        if (rq[b]) begin if ($urandom_range(0, 4) == 0) rq[b] = 1'b0; end
        else if ($urandom_range(0, 2) == 0) rq[b] = 1'b1;
      end
      r = ($urandom_range(0, 79) == 0);
      tick(r, rq, N'($urandom));
      ex = exp_gnt();
      n_checks++;
      if (gnt !== ex) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b expected %b", c, gnt, ex); end
      n_checks++;
      if (busy !== exp_busy()) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy, exp_busy()); end
      n_checks++;
      if (timeout !== m_to) begin n_fail++; $display("FAIL rnd_timeout c%0d: got %b expected %b", c, timeout, m_to); end
      n_checks++;
      if (res_state !== m_res) begin n_fail++; $display("FAIL rnd_res c%0d: got %b expected %b", c, res_state, m_res); end
      n_checks++;
      if ($countones(gnt) > 1) begin n_fail++; $display("FAIL rnd_onehot c%0d: got %b expected at most one bit", c, gnt); end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    a   = '0;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_res_state();
    test_reset_mid();
    test_release_at_expiry();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
